// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int DATA_W = 8;

  // Default PC vector and the opcode bit that flags a two-byte instruction.
  localparam logic [DATA_W-1:0] RESET_VECTOR_DEF = 8'h00;
  localparam int                LONG_BIT_DEF     = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_OP  = 2'd1,
    REQ_ARG = 2'd2,
    ISSUE   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steers the external program counter, reads
// one- or two-byte instructions over req/ack and hands them to the decoder
// under valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | post-reset settle cycle, PC held at the vector
// REQ_OP  | requesting the opcode byte at the current PC
// REQ_ARG | requesting the operand byte of a long instruction
// ISSUE   | instruction presented to the decoder, waiting for ready
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int                LONG_BIT     = LONG_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_in,
  output logic              pc_sel,
  output logic [DATA_W-1:0] pc_load_val,
  output logic              pc_down,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [DATA_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_long
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         in_req;
  logic         ack_taken;

  assign in_req    = (state_q == REQ_OP) || (state_q == REQ_ARG);
  // A branch in the same cycle wins, so its ack is simply dropped.
  assign ack_taken = in_req && mem_ack && !branch_valid;

  // Next-state decode; a branch always restarts fetching at the target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ_OP;
      REQ_OP:  if (mem_ack) state_d = mem_rdata[LONG_BIT] ? REQ_ARG : ISSUE;
      REQ_ARG: if (mem_ack) state_d = ISSUE;
      ISSUE:   if (instr_ready) state_d = REQ_OP;
      default: state_d = IDLE;
    endcase
    if (branch_valid) state_d = REQ_OP;
  end

  // PC steering: hold by reloading the current value, count only on a taken ack.
  always_comb begin
    pc_sel      = 1'b1;
    pc_load_val = pc_in;
    if (!reset) begin
      pc_load_val = RESET_VECTOR;
    end else if (branch_valid) begin
      pc_load_val = branch_target;
    end else if (ack_taken) begin
      pc_sel = 1'b0;
    end
  end

  // State register and instruction capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_long    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ack_taken && (state_q == REQ_OP)) begin
        instr_opcode  <= mem_rdata;
        instr_operand <= '0;
        instr_long    <= 1'b0;
      end
      if (ack_taken && (state_q == REQ_ARG)) begin
        instr_operand <= mem_rdata;
        instr_long    <= 1'b1;
      end
    end
  end

  assign mem_req     = in_req;
  assign instr_valid = (state_q == ISSUE);
  assign mem_addr    = pc_in;
  assign pc_down     = 1'b0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC counter and program memory around
// the DUT, an architectural fetch model feeding a scoreboard, directed cases
// followed by randomized ready/wait/branch traffic.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pc_in = 8'h5A;
  logic       pc_sel;
  logic [7:0] pc_load_val;
  logic       pc_down;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       branch_valid = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_long;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_sel(pc_sel),
    .pc_load_val(pc_load_val), .pc_down(pc_down), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_long(instr_long)
  );

  always #5 clk = ~clk;

  // Program counter beside the sequencer: load, or count up/down.
  always @(posedge clk)
    pc_in <= pc_sel ? pc_load_val : (pc_down ? pc_in - 8'd1 : pc_in + 8'd1);

  // Program memory: ack after wait_cycles cycles of a steady request.
  logic [7:0] mem [256];
  int         wait_cycles = 0;
  int         age = 0;
  logic [7:0] prev_addr = 8'h00;
  always begin
    @(posedge clk); #1;
    if (!mem_req) begin
      age       = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
    end else begin
      if (mem_addr != prev_addr || mem_ack) age = 0;
      mem_ack   = (age >= wait_cycles);
      mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
      if (!mem_ack) age++;
    end
    prev_addr = mem_addr;
  end

  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Architectural model: the instruction at model_pc and the PC that follows it.
  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic       lng;
    logic [7:0] nxt;
  } exp_t;
  exp_t       sb_q[$];
  logic [7:0] model_pc = 8'h00;
  bit         sb_en = 1'b0;

  function automatic void model_push();
    exp_t e;
    e.op  = mem[model_pc];
    e.lng = e.op[LONG_BIT_DEF];
    e.arg = e.lng ? mem[8'(model_pc + 8'd1)] : 8'h00;
    e.nxt = e.lng ? 8'(model_pc + 8'd2) : 8'(model_pc + 8'd1);
    model_pc = e.nxt;
    sb_q.push_back(e);
  endfunction

  function automatic void redirect(input logic [7:0] t);
    sb_q.delete();
    model_pc = t;
    model_push();
  endfunction

  // Monitor: scoreboard pops on each accepted instruction, plus per-cycle rules.
  int         hs_count = 0;
  bit         have_prev = 1'b0;
  logic [7:0] exp_pc_next = 8'h00;
  bit         prev_hold = 1'b0;
  logic [16:0] prev_fields = '0;
  bit         prev_acc = 1'b0;
  bit         prev_valid = 1'b0;
  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (have_prev) begin
      chk("pc_step", 32'(pc_in), 32'(exp_pc_next));
      chk("addr_eq_pc", 32'(mem_addr), 32'(pc_in));
      chk("pc_down_zero", 32'(pc_down), 0);
      chk("req_valid_excl", 32'(mem_req & instr_valid), 0);
    end
    if (prev_hold) begin
      chk("valid_held", 32'(instr_valid), 1);
      chk("fields_stable", 32'({instr_opcode, instr_operand, instr_long}), 32'(prev_fields));
    end
    if (reset && instr_valid && !prev_valid)
      chk("valid_after_ack", 32'(prev_acc), 1);
    if (sb_en && reset && instr_valid && instr_ready && !branch_valid) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb_q.pop_front();
        chk("opcode", 32'(instr_opcode), 32'(e.op));
        chk("operand", 32'(instr_operand), 32'(e.arg));
        chk("long", 32'(instr_long), 32'(e.lng));
        chk("pc_after", 32'(pc_in), 32'(e.nxt));
        model_push();
      end
    end
    have_prev = 1'b1;
    if (!reset) exp_pc_next = RESET_VECTOR_DEF;
    else if (branch_valid) exp_pc_next = branch_target;
    else if (mem_req && mem_ack) exp_pc_next = pc_in + 8'd1;
    else exp_pc_next = pc_in;
    prev_hold   = reset && instr_valid && !instr_ready && !branch_valid;
    prev_fields = {instr_opcode, instr_operand, instr_long};
    prev_acc    = reset && mem_req && mem_ack && !branch_valid;
    prev_valid  = instr_valid;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_hs(input string name);
    int start;
    int n;
    start = hs_count;
    n = 0;
    while (hs_count == start && n < 60) begin
      tick();
      n++;
    end
    if (hs_count == start) chk({name, "_timeout"}, 0, 1);
  endtask

  // Stimulus: directed cases, then randomized traffic.
  initial begin : stim
    int n;
    int start_hs;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h12;
    mem[8'h05] = 8'h85;
    mem[8'h06] = 8'h3C;
    mem[8'h07] = 8'hA1;
    mem[8'h08] = 8'h55;
    mem[8'h40] = 8'h21;
    instr_ready = 1'b1;

    // Reset for two edges, from a counter value away from the vector.
    tick();
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc_sel", 32'(pc_sel), 1);
    chk("rst_load_val", 32'(pc_load_val), 0);
    chk("rst_pc", 32'(pc_in), 0);
    tick();
    reset = 1'b1;
    redirect(8'h00);
    sb_en = 1'b1;

    // First request lands at the vector, no valid before it.
    n = 0;
    do begin
      @(negedge clk);
      chk("no_valid_before_req", 32'(instr_valid), 0);
      n++;
    end while (!mem_req && n < 6);
    chk("first_req", 32'(mem_req), 1);
    chk("first_req_pc", 32'(pc_in), 0);

    // One-byte 8'h12 with zero wait.
    wait_hs("short_hs");

    // Branch to 8'h05: long instruction with two wait cycles per byte, decoder stalled.
    branch_valid  = 1'b1;
    branch_target = 8'h05;
    redirect(8'h05);
    wait_cycles = 2;
    instr_ready = 1'b0;
    tick();
    branch_valid = 1'b0;
    @(negedge clk);
    chk("wait_pc_hold0", 32'(pc_in), 5);
    chk("wait_no_ack0", 32'(mem_ack), 0);
    tick();
    @(negedge clk);
    chk("wait_pc_hold1", 32'(pc_in), 5);
    chk("wait_no_ack1", 32'(mem_ack), 0);
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("long_valid_seen", 32'(instr_valid), 1);

    // Stalled in issue for four cycles.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_opcode", 32'(instr_opcode), 32'h85);
      chk("stall_operand", 32'(instr_operand), 32'h3C);
      chk("stall_long", 32'(instr_long), 1);
      chk("stall_no_req", 32'(mem_req), 0);
      chk("stall_pc", 32'(pc_in), 7);
    end
    tick();
    wait_cycles = 0;
    instr_ready = 1'b1;
    wait_hs("long_hs");

    // Branch to 8'h40 in the cycle of the operand ack at 8'h08.
    tick();
    mem[8'hFF] = 8'h90;
    mem[8'h00] = 8'h77;
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    redirect(8'h40);
    @(negedge clk);
    chk("arg_ack_pc", 32'(pc_in), 8);
    chk("arg_ack_seen", 32'(mem_req & mem_ack), 1);
    tick();
    branch_valid = 1'b0;
    @(negedge clk);
    chk("branch_pc", 32'(pc_in), 32'h40);
    chk("branch_req", 32'(mem_req), 1);
    chk("branch_no_valid", 32'(instr_valid), 0);
    wait_hs("br40_hs");

    // Long opcode at 8'hFF wraps its operand fetch to 8'h00.
    branch_valid  = 1'b1;
    branch_target = 8'hFF;
    redirect(8'hFF);
    tick();
    branch_valid = 1'b0;
    wait_hs("wrap_hs");
    chk("wrap_pc", 32'(pc_in), 1);

    // Randomized traffic over a fresh memory image.
    foreach (mem[i]) mem[i] = 8'($urandom);
    branch_valid  = 1'b1;
    branch_target = 8'($urandom);
    redirect(branch_target);
    start_hs = hs_count;
    for (int c = 0; c < 3000; c++) begin
      tick();
      instr_ready = ($urandom_range(9) < 7);
      wait_cycles = $urandom_range(3);
      if (branch_valid) begin
        branch_valid = 1'b0;
      end else if ($urandom_range(15) == 0) begin
        branch_valid  = 1'b1;
        branch_target = 8'($urandom);
        redirect(branch_target);
      end
    end
    tick();
    branch_valid = 1'b0;
    repeat (3) tick();
    chk("random_hs_count", 32'((hs_count - start_hs) >= 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
